// File: rtl/udmon_pkg.sv
// -----------------------------------------------------------------------------
// udmon_pkg
// Shared types and constants for the up/down count monitor.
//   udmon_state_e : monitor FSM states (INIT / LOST / UP / DOWN)
//   udmon_class_e : classification of one prev->cur step (HOLD / UP / DOWN / ERR)
//   DIR_UP / DIR_DOWN : encoding of the inferred direction output
//                       (mirrors the counter's mode input M)
// -----------------------------------------------------------------------------
package udmon_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOST = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } udmon_state_e;

    typedef enum logic [1:0] {
        CLS_HOLD = 2'd0,
        CLS_UP   = 2'd1,
        CLS_DOWN = 2'd2,
        CLS_ERR  = 2'd3
    } udmon_class_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/udmon_step_classify.sv
// -----------------------------------------------------------------------------
// udmon_step_classify
// Purely combinational comparison of the previous and current count values,
// modulo 2^WIDTH.
// Ports:
//   prev  in  WIDTH  previously sampled count
//   cur   in  WIDTH  currently sampled count
//   cls   out 2      step class (HOLD / UP / DOWN / ERR)
//   wrap  out 1      UP step from all-ones, or DOWN step from zero
// -----------------------------------------------------------------------------
module udmon_step_classify
    import udmon_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output udmon_class_e     cls,
    output logic             wrap
);

    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;

    always_comb begin
        // Natural WIDTH-bit overflow gives the modulo arithmetic for free.
        prev_inc = prev + WIDTH'(1);
        prev_dec = prev - WIDTH'(1);
        cls      = CLS_ERR;
        wrap     = 1'b0;
        if (cur == prev) begin
            cls = CLS_HOLD;
        end else if (cur == prev_inc) begin
            cls  = CLS_UP;
            wrap = (prev == {WIDTH{1'b1}});
        end else if (cur == prev_dec) begin
            cls  = CLS_DOWN;
            wrap = (prev == {WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/updown_count_monitor.sv
// -----------------------------------------------------------------------------
// updown_count_monitor
// Receive-side checker for an up/down counter's count bus. Infers the counting
// direction, flags wrap-around and illegal steps, tracks run length and a
// saturating error count. All outputs are registered: one cycle after the
// sampling edge.
//
// Optional feature macro: UDMON_STICKY_ERR_EN adds err_clr / err_sticky.
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous active-high reset (wins over sample_en)
//   count_in    in   WIDTH  observed counter value
//   sample_en   in   1      count_in valid this cycle
//   err_clr     in   1      (UDMON_STICKY_ERR_EN) clear sticky error flag
//   err_sticky  out  1      (UDMON_STICKY_ERR_EN) set on any illegal step
//   dir         out  1      inferred direction, DIR_UP=0 / DIR_DOWN=1
//   dir_valid   out  1      state is UP or DOWN
//   dir_chg     out  1      pulse on UP<->DOWN transition
//   wrap_pulse  out  1      pulse on max->0 (up) or 0->max (down) step
//   err_pulse   out  1      pulse on illegal step
//   run_len     out  RUN_W  consecutive steps in current direction (saturating)
//   err_count   out  ERR_W  illegal steps since reset (saturating)
//   fsm_state   out  2      debug view of the monitor FSM state
//
// Handshake: sample_en is a valid-only qualifier. There is no ready; every
// cycle with sample_en=1 is consumed and classified, every cycle with
// sample_en=0 leaves all state untouched and produces no pulses.
// -----------------------------------------------------------------------------
module updown_count_monitor
    import udmon_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RUN_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample_en,
`ifdef UDMON_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             dir,
    output logic             dir_valid,
    output logic             dir_chg,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [RUN_W-1:0] run_len,
    output logic [ERR_W-1:0] err_count,
    output udmon_state_e     fsm_state
);

    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    udmon_state_e     state_q;
    udmon_state_e     state_d;
    logic [WIDTH-1:0] prev_q;
    udmon_class_e     cls;
    logic             wrap;
    logic             same_dir;
    logic             reverse;

    udmon_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev (prev_q),
        .cur  (count_in),
        .cls  (cls),
        .wrap (wrap)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (sample_en) begin
            if (state_q == ST_INIT) begin
                // First sample only primes prev; there is nothing to compare yet.
                state_d = ST_LOST;
            end else begin
                unique case (cls)
                    CLS_UP:   state_d = ST_UP;
                    CLS_DOWN: state_d = ST_DOWN;
                    CLS_ERR:  state_d = ST_LOST;
                    default:  state_d = state_q;
                endcase
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dir_valid = (state_q == ST_UP) || (state_q == ST_DOWN);
        fsm_state = state_q;
    end

    // A step continuing the current locked direction extends the run; a step
    // against it is a reversal. Steps out of LOST are neither.
    always_comb begin
        same_dir = ((state_q == ST_UP)   && (cls == CLS_UP)) ||
                   ((state_q == ST_DOWN) && (cls == CLS_DOWN));
        reverse  = ((state_q == ST_UP)   && (cls == CLS_DOWN)) ||
                   ((state_q == ST_DOWN) && (cls == CLS_UP));
    end

    // ---------------- Datapath: prev, direction, pulses, counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            dir        <= DIR_UP;
            dir_chg    <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            run_len    <= '0;
            err_count  <= '0;
        end else begin
            dir_chg    <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (sample_en) begin
                prev_q <= count_in;
                if (state_q != ST_INIT) begin
                    // wrap is only ever raised for UP/DOWN classes, so it can
                    // never coincide with err_pulse.
                    wrap_pulse <= wrap;
                    err_pulse  <= (cls == CLS_ERR);
                    dir_chg    <= reverse;
                    unique case (cls)
                        CLS_UP, CLS_DOWN: begin
                            dir <= (cls == CLS_UP) ? DIR_UP : DIR_DOWN;
                            if (same_dir) begin
                                if (run_len != RUN_MAX) begin
                                    run_len <= run_len + RUN_W'(1);
                                end
                            end else begin
                                run_len <= RUN_W'(1);
                            end
                        end
                        CLS_ERR: begin
                            run_len <= '0;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

`ifdef UDMON_STICKY_ERR_EN
    // Sticky flag: a same-cycle illegal step beats the clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (sample_en && (state_q != ST_INIT) && (cls == CLS_ERR)) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_updown_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_updown_count_monitor
// Directed self-checking bench for updown_count_monitor (WIDTH=4, RUN_W=8,
// ERR_W=8). Inputs are driven 1 time unit after the rising edge; outputs are
// checked at that same point, i.e. they reflect the sample taken on that edge.
// Build with +define+UDMON_STICKY_ERR_EN to include the sticky-error tests.
// -----------------------------------------------------------------------------
module tb_updown_count_monitor;
    import udmon_pkg::*;

    localparam int WIDTH = 4;
    localparam int RUN_W = 8;
    localparam int ERR_W = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count_in;
    logic             sample_en;
`ifdef UDMON_STICKY_ERR_EN
    logic             err_clr;
    logic             err_sticky;
`endif
    logic             dir;
    logic             dir_valid;
    logic             dir_chg;
    logic             wrap_pulse;
    logic             err_pulse;
    logic [RUN_W-1:0] run_len;
    logic [ERR_W-1:0] err_count;
    udmon_state_e     fsm_state;

    int n_checks;
    int n_errors;

    logic [RUN_W-1:0] exp_q[$];

    updown_count_monitor #(
        .WIDTH (WIDTH),
        .RUN_W (RUN_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .sample_en  (sample_en),
`ifdef UDMON_STICKY_ERR_EN
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
`endif
        .dir        (dir),
        .dir_valid  (dir_valid),
        .dir_chg    (dir_chg),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .run_len    (run_len),
        .err_count  (err_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset     = 1'b1;
        sample_en = 1'b0;
        count_in  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic sample(input logic [WIDTH-1:0] v);
        count_in  = v;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [WIDTH-1:0] v);
        count_in  = v;
        sample_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulses(input string tag, input logic dc, input logic wp, input logic ep);
        check({tag, "_dir_chg"}, 32'(dir_chg), 32'(dc));
        check({tag, "_wrap"},    32'(wrap_pulse), 32'(wp));
        check({tag, "_err"},     32'(err_pulse), 32'(ep));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        sample_en = 1'b0;
        count_in  = '0;
`ifdef UDMON_STICKY_ERR_EN
        err_clr   = 1'b0;
`endif
        do_reset();

        // Reset state
        check("rst_state", 32'(fsm_state), 32'(ST_INIT));
        check("rst_dir", 32'(dir), 0);
        check("rst_dir_valid", 32'(dir_valid), 0);
        check("rst_run", 32'(run_len), 0);
        check("rst_errc", 32'(err_count), 0);
        check_pulses("rst", 1'b0, 1'b0, 1'b0);

        // Test 1: 0..15,0,1 counting up
        sample(4'd0);
        check("t1_prime_state", 32'(fsm_state), 32'(ST_LOST));
        check("t1_prime_valid", 32'(dir_valid), 0);
        check("t1_prime_run", 32'(run_len), 0);
        check_pulses("t1_prime", 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) exp_q.push_back(RUN_W'(i));
        for (int i = 1; i <= 17; i++) begin
            sample(WIDTH'(i % 16));
            check("t1_run", 32'(run_len), 32'(exp_q.pop_front()));
            check("t1_dir", 32'(dir), 0);
            check("t1_valid", 32'(dir_valid), 1);
            check_pulses("t1", 1'b0, (i == 16), 1'b0);
        end
        check("t1_errc", 32'(err_count), 0);

        // Test 2: up 5,6,7 then down 6,5,4
        do_reset();
        sample(4'd5);
        sample(4'd6);
        check("t2_run_a", 32'(run_len), 1);
        sample(4'd7);
        check("t2_run_b", 32'(run_len), 2);
        check("t2_dir_up", 32'(dir), 0);
        sample(4'd6);
        check_pulses("t2_rev", 1'b1, 1'b0, 1'b0);
        check("t2_dir_dn", 32'(dir), 1);
        check("t2_run_reload", 32'(run_len), 1);
        check("t2_state", 32'(fsm_state), 32'(ST_DOWN));
        sample(4'd5);
        check("t2_dir_chg_once", 32'(dir_chg), 0);
        sample(4'd4);
        check("t2_run_end", 32'(run_len), 3);
        check("t2_dir_end", 32'(dir), 1);

        // Test 3: down 1,0,15,14 with wrap at 0->15
        do_reset();
        sample(4'd1);
        sample(4'd0);
        check_pulses("t3_exit_lost", 1'b0, 1'b0, 1'b0);
        check("t3_dir", 32'(dir), 1);
        check("t3_run_a", 32'(run_len), 1);
        sample(4'd15);
        check_pulses("t3_wrap", 1'b0, 1'b1, 1'b0);
        check("t3_dir_wrap", 32'(dir), 1);
        check("t3_run_b", 32'(run_len), 2);
        sample(4'd14);
        check_pulses("t3_after", 1'b0, 1'b0, 1'b0);
        check("t3_run_c", 32'(run_len), 3);

        // Test 4: 3,4,6,7 illegal step, then reversal and re-lock out of LOST
        do_reset();
        sample(4'd3);
        sample(4'd4);
        sample(4'd6);
        check_pulses("t4_err", 1'b0, 1'b0, 1'b1);
        check("t4_errc", 32'(err_count), 1);
        check("t4_run", 32'(run_len), 0);
        check("t4_valid", 32'(dir_valid), 0);
        check("t4_state_lost", 32'(fsm_state), 32'(ST_LOST));
        sample(4'd7);
        check("t4_state_up", 32'(fsm_state), 32'(ST_UP));
        check("t4_run_relock", 32'(run_len), 1);
        check_pulses("t4_relock", 1'b0, 1'b0, 1'b0);
        sample(4'd6);
        check("t4_rev_chg", 32'(dir_chg), 1);
        sample(4'd9);
        check("t4_errc2", 32'(err_count), 2);
        check("t4_dir_hold_lost", 32'(dir), 1);
        sample(4'd10);
        check_pulses("t4_exit_lost_up", 1'b0, 1'b0, 1'b0);
        check("t4_dir_up", 32'(dir), 0);
        check("t4_run_load", 32'(run_len), 1);

        // Test 5: HOLD steps with sample_en toggling, then mid-sequence reset
        do_reset();
        sample(4'd8);
        sample(4'd9);
        idle(4'd9);
        check("t5_idle_run", 32'(run_len), 1);
        sample(4'd9);
        check_pulses("t5_hold", 1'b0, 1'b0, 1'b0);
        check("t5_hold_run", 32'(run_len), 1);
        check("t5_hold_state", 32'(fsm_state), 32'(ST_UP));
        idle(4'd3);
        check("t5_idle_errc", 32'(err_count), 0);
        sample(4'd9);
        check_pulses("t5_hold2", 1'b0, 1'b0, 1'b0);
        check("t5_hold2_run", 32'(run_len), 1);
        check("t5_hold2_dir", 32'(dir), 0);
        sample(4'd10);
        check("t5_run_grow", 32'(run_len), 2);
        reset    = 1'b1;
        sample(4'd5);
        reset    = 1'b0;
        check("t5_rst_state", 32'(fsm_state), 32'(ST_INIT));
        check("t5_rst_run", 32'(run_len), 0);
        check("t5_rst_valid", 32'(dir_valid), 0);
        check_pulses("t5_rst", 1'b0, 1'b0, 1'b0);
        sample(4'd5);
        check("t5_prime_state", 32'(fsm_state), 32'(ST_LOST));
        check_pulses("t5_prime", 1'b0, 1'b0, 1'b0);

        // Saturation: 300 up steps, run_len stops at 255
        do_reset();
        sample(4'd0);
        for (int i = 1; i <= 300; i++) sample(WIDTH'(i % 16));
        check("sat_run", 32'(run_len), 255);

        // Saturation: 260 illegal steps, err_count stops at 255
        do_reset();
        sample(4'd0);
        for (int i = 1; i <= 260; i++) sample((i % 2) ? 4'd8 : 4'd0);
        check("sat_errc", 32'(err_count), 255);
        check_pulses("sat_err", 1'b0, 1'b0, 1'b1);

`ifdef UDMON_STICKY_ERR_EN
        // Sticky error flag
        do_reset();
        check("st_rst", 32'(err_sticky), 0);
        sample(4'd3);
        sample(4'd5);
        check("st_set", 32'(err_sticky), 1);
        idle(4'd5);
        check("st_hold", 32'(err_sticky), 1);
        err_clr = 1'b1;
        idle(4'd5);
        err_clr = 1'b0;
        check("st_clr", 32'(err_sticky), 0);
        err_clr = 1'b1;
        sample(4'd9);
        err_clr = 1'b0;
        check("st_set_wins", 32'(err_sticky), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
